// File: rtl/dataflow_deadlock_monitor.sv
// Run-time deadlock monitor for an N-process dataflow region.
// Waits until the blocked/wait-for pattern is stable, then walks the wait-for graph one hop
// per cycle from a round-robin origin. When the walk returns to the origin, it reports the
// cycle and holds the report until it is acknowledged.
module dataflow_deadlock_monitor #(
    parameter int unsigned N_PROC        = 3,
    parameter int unsigned IDX_W         = (N_PROC > 1) ? $clog2(N_PROC) : 1,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_PROC-1:0]          blk_vld,
    input  logic [N_PROC*N_PROC-1:0]   blk_dep,
    output logic                       dl_detect,
    output logic [IDX_W-1:0]           dl_origin,
    output logic [N_PROC-1:0]          dl_members,
    input  logic                       dl_ack,
    output logic                       scan_busy
);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_REPORT, S_WAIT_CLEAR} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] STABLE_TGT = CNT_W'(STABLE_CYCLES);

    state_t                     state_q, state_d;
    logic [N_PROC-1:0]          prev_vld_q, prev_vld_d;
    logic [N_PROC*N_PROC-1:0]   prev_dep_q, prev_dep_d;
    logic [CNT_W-1:0]           stable_cnt_q, stable_cnt_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]           origin_q, origin_d;
    logic [IDX_W-1:0]           cur_q, cur_d;
    logic [N_PROC-1:0]          visited_q, visited_d;
    logic [N_PROC-1:0]          snap_vld_q, snap_vld_d;
    logic [N_PROC*N_PROC-1:0]   snap_dep_q, snap_dep_d;
    logic [IDX_W-1:0]           dl_origin_q, dl_origin_d;
    logic [N_PROC-1:0]          dl_members_q, dl_members_d;

    logic                       stable;
    logic [CNT_W-1:0]           cnt_inc;
    logic                       live_match;
    logic [IDX_W-1:0]           rr_origin;
    logic                       rr_found;
    logic [N_PROC-1:0]          cur_row;
    logic [IDX_W-1:0]           nxt_idx;
    logic                       nxt_found;
    logic [N_PROC-1:0]          visited_cur;
    logic [IDX_W-1:0]           origin_inc;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_PROC) s = s - N_PROC;
        return IDX_W'(s);
    endfunction

    // Stability qualification, round-robin origin search and wait-for row lookup
    always_comb begin
        stable     = (blk_vld == prev_vld_q) && (blk_dep == prev_dep_q) && (|blk_vld);
        cnt_inc    = (stable_cnt_q == CNT_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
        live_match = (blk_vld == snap_vld_q) && (blk_dep == snap_dep_q);
        origin_inc = (origin_q == IDX_W'(N_PROC - 1)) ? '0 : origin_q + 1'b1;

        rr_origin = rr_ptr_q;
        rr_found  = 1'b0;
        for (int unsigned k = 0; k < N_PROC; k++) begin
            if (!rr_found && blk_vld[wrap_add(rr_ptr_q, k)]) begin
                rr_found  = 1'b1;
                rr_origin = wrap_add(rr_ptr_q, k);
            end
        end

        cur_row = '0;
        for (int unsigned i = 0; i < N_PROC; i++) begin
            if (IDX_W'(i) == cur_q) cur_row = snap_dep_q[i*N_PROC +: N_PROC];
        end

        nxt_idx   = '0;
        nxt_found = 1'b0;
        for (int unsigned i = 0; i < N_PROC; i++) begin
            if (!nxt_found && cur_row[i]) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(i);
            end
        end

        visited_cur = visited_q | (N_PROC'(1) << cur_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        prev_vld_d   = blk_vld;
        prev_dep_d   = blk_dep;
        stable_cnt_d = stable ? cnt_inc : '0;
        rr_ptr_d     = rr_ptr_q;
        origin_d     = origin_q;
        cur_d        = cur_q;
        visited_d    = visited_q;
        snap_vld_d   = snap_vld_q;
        snap_dep_d   = snap_dep_q;
        dl_origin_d  = dl_origin_q;
        dl_members_d = dl_members_q;

        case (state_q)
            S_IDLE: begin
                if (enable && (stable_cnt_d == STABLE_TGT)) begin
                    state_d    = S_WALK;
                    origin_d   = rr_origin;
                    cur_d      = rr_origin;
                    visited_d  = '0;
                    snap_vld_d = blk_vld;
                    snap_dep_d = blk_dep;
                end
            end
            S_WALK: begin
                visited_d = visited_cur;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (!live_match || !nxt_found || !snap_vld_q[nxt_idx] ||
                             (visited_cur[nxt_idx] && (nxt_idx != origin_q))) begin
                    state_d      = S_IDLE;
                    rr_ptr_d     = origin_inc;
                    stable_cnt_d = '0;
                end else if (nxt_idx == origin_q) begin
                    state_d      = S_REPORT;
                    dl_members_d = visited_cur;
                    dl_origin_d  = origin_q;
                end else begin
                    cur_d = nxt_idx;
                end
            end
            S_REPORT: begin
                if (dl_ack) state_d = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                if (!enable || ((dl_members_q & ~blk_vld) != '0) || (blk_dep != snap_dep_q)) begin
                    state_d      = S_IDLE;
                    stable_cnt_d = '0;
                    dl_members_d = '0;
                    dl_origin_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            prev_vld_q   <= '0;
            prev_dep_q   <= '0;
            stable_cnt_q <= '0;
            rr_ptr_q     <= '0;
            origin_q     <= '0;
            cur_q        <= '0;
            visited_q    <= '0;
            snap_vld_q   <= '0;
            snap_dep_q   <= '0;
            dl_origin_q  <= '0;
            dl_members_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_vld_q   <= prev_vld_d;
            prev_dep_q   <= prev_dep_d;
            stable_cnt_q <= stable_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            origin_q     <= origin_d;
            cur_q        <= cur_d;
            visited_q    <= visited_d;
            snap_vld_q   <= snap_vld_d;
            snap_dep_q   <= snap_dep_d;
            dl_origin_q  <= dl_origin_d;
            dl_members_q <= dl_members_d;
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        dl_detect  = (state_q == S_REPORT);
        scan_busy  = (state_q == S_WALK);
        dl_origin  = dl_origin_q;
        dl_members = dl_members_q;
    end

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Scoreboard bench for dataflow_deadlock_monitor (N_PROC=3, STABLE_CYCLES=16).
// Stimulus pushes the expected report (edge number, origin, members) into a queue, and a
// monitor pops one entry and compares it on every rising edge of dl_detect.
module tb_dataflow_deadlock_monitor;
    localparam int unsigned N  = 3;
    localparam int unsigned IW = 2;

    logic           clock = 1'b0;
    logic           reset, enable, dl_ack;
    logic [N-1:0]   blk_vld;
    logic [N*N-1:0] blk_dep;
    logic           dl_detect, scan_busy;
    logic [IW-1:0]  dl_origin;
    logic [N-1:0]   dl_members;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int            cyc;
        logic [IW-1:0] origin;
        logic [N-1:0]  members;
    } rep_t;
    rep_t exp_q[$];
    rep_t mon_r;
    logic det_prev = 1'b0;

    // Rows: row2 in [8:6], row1 in [5:3], row0 in [2:0]
    localparam logic [N*N-1:0] DEP_PAIR  = 9'b010_100_000;
    localparam logic [N*N-1:0] DEP_SELF  = 9'b100_000_000;
    localparam logic [N*N-1:0] DEP_CHAIN = 9'b000_000_010;

    dataflow_deadlock_monitor #(.N_PROC(N), .STABLE_CYCLES(16), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .blk_vld    (blk_vld),
        .blk_dep    (blk_dep),
        .dl_detect  (dl_detect),
        .dl_origin  (dl_origin),
        .dl_members (dl_members),
        .dl_ack     (dl_ack),
        .scan_busy  (scan_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Report monitor
    always @(negedge clock) begin
        if (dl_detect && !det_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_report: origin %0d members %b at edge %0d, none expected",
                         dl_origin, dl_members, cyc);
            end else begin
                mon_r = exp_q.pop_front();
                chk("report_edge", cyc, mon_r.cyc);
                chk("report_origin", 32'(dl_origin), 32'(mon_r.origin));
                chk("report_members", 32'(dl_members), 32'(mon_r.members));
            end
        end
        det_prev = dl_detect;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        dl_ack  = 1'b0;
        blk_vld = '0;
        blk_dep = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic expect_report(input int c, input logic [IW-1:0] o, input logic [N-1:0] m);
        rep_t r;
        r.cyc     = c;
        r.origin  = o;
        r.members = m;
        exp_q.push_back(r);
    endtask

    function automatic logic [6:0] all_out();
        return {dl_detect, scan_busy, dl_origin, dl_members};
    endfunction

    initial begin
        int t0;
        int cnt;
        int busy_edges[$];

        reset = 1'b1; enable = 1'b0; dl_ack = 1'b0; blk_vld = '0; blk_dep = '0;

        // Reset state and idle quiet period
        do_reset();
        chk("reset_outputs", 32'(all_out()), 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (all_out() != '0) cnt++;
        end
        chk("idle_quiet_cycles", cnt, 0);

        // Two-process cycle 1->2->1, then hold, ack, clear and re-report
        do_reset();
        t0 = cyc;
        blk_vld = 3'b110;
        blk_dep = DEP_PAIR;
        expect_report(t0 + 19, 2'd1, 3'b110);
        cnt = 0;
        for (int i = 0; i < 19; i++) begin
            tick(1);
            if (scan_busy) cnt++;
        end
        chk("pair_walk_cycles", cnt, 2);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (dl_detect && dl_origin == 2'd1 && dl_members == 3'b110) cnt++;
        end
        chk("pair_held_cycles", cnt, 50);
        dl_ack = 1'b1;
        tick(1);
        dl_ack = 1'b0;
        chk("ack_drops_detect", 32'(dl_detect), 0);
        chk("wait_clear_members", 32'(dl_members), 32'(3'b110));
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (dl_detect || scan_busy) cnt++;
        end
        chk("wait_clear_no_rereport", cnt, 0);
        blk_vld = 3'b100;
        tick(1);
        chk("clear_members", 32'(dl_members), 0);
        tick(3);
        t0 = cyc;
        blk_vld = 3'b110;
        expect_report(t0 + 19, 2'd1, 3'b110);
        tick(20);
        chk("rereport_detect", 32'(dl_detect), 1);

        // Self-loop on process 2; ack arriving on the entry edge is ignored
        do_reset();
        t0 = cyc;
        blk_vld = 3'b100;
        blk_dep = DEP_SELF;
        expect_report(t0 + 18, 2'd2, 3'b100);
        tick(17);
        dl_ack = 1'b1;
        tick(1);
        dl_ack = 1'b0;
        tick(2);
        chk("ack_on_entry_ignored", 32'(dl_detect), 1);

        // Chain 0->1 with 1 not blocked: repeated one-cycle walks, no report
        do_reset();
        t0 = cyc;
        blk_vld = 3'b001;
        blk_dep = DEP_CHAIN;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (scan_busy) busy_edges.push_back(cyc - t0);
        end
        chk("chain_walk_count", busy_edges.size(), 3);
        chk("chain_walk0_edge", (busy_edges.size() > 0) ? busy_edges[0] : -1, 17);
        chk("chain_walk1_edge", (busy_edges.size() > 1) ? busy_edges[1] : -1, 34);
        chk("chain_walk2_edge", (busy_edges.size() > 2) ? busy_edges[2] : -1, 51);
        chk("chain_rr_ptr", 32'(dut.rr_ptr_q), 1);

        // Reset in the middle of a walk
        t0 = cyc;
        blk_vld = 3'b110;
        blk_dep = DEP_PAIR;
        tick(18);
        chk("midwalk_busy", 32'(scan_busy), 1);
        reset = 1'b1;
        tick(1);
        chk("midwalk_reset_outputs", 32'(all_out()), 0);
        chk("midwalk_reset_rr_ptr", 32'(dut.rr_ptr_q), 0);
        blk_vld = '0;
        blk_dep = '0;
        reset = 1'b0;
        tick(2);

        // Input change at stable_cnt=10 restarts qualification
        do_reset();
        t0 = cyc;
        blk_vld = 3'b110;
        blk_dep = DEP_PAIR;
        tick(11);
        blk_dep[0] = 1'b1;
        expect_report(t0 + 30, 2'd1, 3'b110);
        tick(20);
        chk("delayed_detect", 32'(dl_detect), 1);

        // Reset while a report is held
        reset = 1'b1;
        tick(1);
        chk("midreport_reset_outputs", 32'(all_out()), 0);
        reset = 1'b0;
        blk_vld = '0;
        blk_dep = '0;
        tick(3);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
